// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the core and the execute-stage ALU.
// The core drives the request side (master), the ALU drives results (slave).
interface alu_seq_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUControl, A, B,
        input  Result, Zero, Negative, Carry, Overflow, busy, done
    );

    modport slave (
        input  start, ALUControl, A, B,
        output Result, Zero, Negative, Carry, Overflow, busy, done
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt, and an iterative
// one-bit-per-cycle shifter for sll/srl/sra behind a start/busy/done handshake.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_exec_if.slave  bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } calc_t;

    state_t                    state, state_nx;
    logic signed [WIDTH-1:0]   shreg;
    logic        [SHAMT_W-1:0] cnt;
    logic        [2:0]         op;
    logic        [SHAMT_W-1:0] shamt;
    logic                      accept;
    logic                      is_shift;
    logic                      last_step;
    calc_t                     calc;
    logic signed [WIDTH-1:0]   shnext;

    // Single-cycle operations; shift codes fall through to "pass A" for k=0.
    function automatic calc_t alu_calc(input logic [2:0] code,
                                       input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b);
        calc_t          r;
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        logic           v_add;
        logic           v_sub;
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        v_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        v_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        r = '0;
        case (code)
            OP_ADD: begin r.res = sum[WIDTH-1:0];  r.c = sum[WIDTH];  r.v = v_add; end
            OP_SUB: begin r.res = diff[WIDTH-1:0]; r.c = diff[WIDTH]; r.v = v_sub; end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_SLT: r.res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ v_sub};
            default: r.res = a;
        endcase
        return r;
    endfunction

    // One step of the iterative shifter.
    function automatic logic signed [WIDTH-1:0] shift_one(input logic [2:0] code,
                                                          input logic signed [WIDTH-1:0] v);
        case (code)
            OP_SLL:  return {v[WIDTH-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign shamt  = bus.B[SHAMT_W-1:0];
    assign calc   = alu_calc(bus.ALUControl, $signed(bus.A), $signed(bus.B));
    assign shnext = shift_one(op, shreg);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: only a shift with a non-zero amount leaves IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_shift && (shamt != '0)) state_nx = SHIFT;
            SHIFT:   if (last_step) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/control decode.
    always_comb begin
        bus.busy  = (state == SHIFT);
        accept    = bus.start && (state == IDLE);
        is_shift  = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL) ||
                    (bus.ALUControl == OP_SRA);
        last_step = (cnt == {{(SHAMT_W-1){1'b0}}, 1'b1});
    end

    // Datapath: load/step the shifter and write Result, flags and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            cnt          <= '0;
            op           <= OP_ADD;
            bus.Result   <= '0;
            bus.Zero     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Carry    <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg <= $signed(bus.A);
                        cnt   <= shamt;
                        op    <= bus.ALUControl;
                    end else begin
                        bus.Result   <= calc.res;
                        bus.Zero     <= (calc.res == '0);
                        bus.Negative <= calc.res[WIDTH-1];
                        bus.Carry    <= calc.c;
                        bus.Overflow <= calc.v;
                        bus.done     <= 1'b1;
                    end
                end
            end else begin
                shreg <= shnext;
                cnt   <= cnt - 1'b1;
                if (last_step) begin
                    bus.Result   <= shnext;
                    bus.Zero     <= (shnext == '0);
                    bus.Negative <= shnext[WIDTH-1];
                    bus.Carry    <= 1'b0;
                    bus.Overflow <= 1'b0;
                    bus.done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: expected results are queued at issue
// and compared (value, flags, latency) when done pulses.
module tb_alu_seq_exec;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef struct {
        logic [31:0] res;
        logic        z, n, c, v;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc = 0;
    exp_t scb[$];
    exp_t last;

    alu_seq_exec_if #(.WIDTH(32)) bus();

    alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] code, input logic [31:0] a,
                                   input logic [31:0] b, input int now);
        exp_t        e;
        logic [32:0] w;
        longint      s;
        int          k;
        k     = int'(b[4:0]);
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.due = now + 1;
        case (code)
            OP_ADD: begin
                w     = {1'b0, a} + {1'b0, b};
                e.res = w[31:0];
                e.c   = w[32];
                s     = longint'($signed(a)) + longint'($signed(b));
                e.v   = (s != longint'($signed(e.res)));
            end
            OP_SUB: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = longint'($signed(a)) - longint'($signed(b));
                e.v   = (s != longint'($signed(e.res)));
            end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL: begin e.res = a << k;                 e.due = now + 1 + k; end
            OP_SRL: begin e.res = a >> k;                 e.due = now + 1 + k; end
            default: begin e.res = 32'($signed(a) >>> k); e.due = now + 1 + k; end
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    // Monitor: on done compare against the scoreboard, otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done) begin
                check("done_while_busy", 64'(bus.busy), 64'd0);
                if (scb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = scb.pop_front();
                    check("result",   64'(bus.Result),   64'(e.res));
                    check("zero",     64'(bus.Zero),     64'(e.z));
                    check("negative", 64'(bus.Negative), 64'(e.n));
                    check("carry",    64'(bus.Carry),    64'(e.c));
                    check("overflow", 64'(bus.Overflow), 64'(e.v));
                    check("latency",  64'(cyc),          64'(e.due));
                    last = e;
                end
            end else begin
                check("hold_result", 64'(bus.Result),
                      64'(last.res));
                check("hold_flags",  64'({bus.Zero, bus.Negative, bus.Carry, bus.Overflow}),
                      64'({last.z, last.n, last.c, last.v}));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 64'(bus.Result), 64'd0);
        check({tag, "_flags"},  64'({bus.Zero, bus.Negative, bus.Carry, bus.Overflow}), 64'd0);
        check({tag, "_busy"},   64'(bus.busy), 64'd0);
        check({tag, "_done"},   64'(bus.done), 64'd0);
    endtask

    // Called at a negedge; asserts reset away from the edge the monitor samples on.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        bus.start = 1'b0;
        scb.delete();
        last = '{res: 32'd0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, due: 0};
        #1 check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        check_reset_outputs({tag, "_held"});
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; waits for the ALU to be free, then presents one request.
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (bus.busy && t < 40) begin
            bus.start = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("busy_timeout", 64'd1, 64'd0);
        scb.push_back(model(code, a, b, cyc));
        bus.start      = 1'b1;
        bus.ALUControl = code;
        bus.A          = a;
        bus.B          = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((scb.size() != 0 || bus.busy) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 64'(t < 60), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.ALUControl = OP_ADD;
        bus.A          = 32'd0;
        bus.B          = 32'd0;
        last = '{res: 32'd0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, due: 0};
        rst = 1'b1;
        @(negedge clk);
        do_reset("por");

        // Reset in the middle of a long sra aborts it silently.
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        repeat (3) @(negedge clk);
        check("sra_busy_before_rst", 64'(bus.busy), 64'd1);
        do_reset("midshift");
        repeat (3) @(negedge clk);
        issue(OP_ADD, 32'd1, 32'd1);
        wait_idle();

        // Signed overflow on add, equal operands on sub.
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        wait_idle();
        issue(OP_SUB, 32'd5, 32'd5);
        wait_idle();

        // Back-to-back slt, two consecutive done pulses.
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(OP_SLT, 32'd1, 32'hFFFF_FFFF);
        wait_idle();

        // srl by 4; a start while busy must be dropped.
        issue(OP_SRL, 32'h8000_0000, 32'd4);
        check("srl_busy", 64'(bus.busy), 64'd1);
        bus.start      = 1'b1;
        bus.ALUControl = OP_ADD;
        bus.A          = 32'd3;
        bus.B          = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // sra by 0 (single cycle), then by the maximum amount.
        issue(OP_SRA, 32'h8000_0000, 32'd0);
        wait_idle();
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        wait_idle();

        // Mixed traffic: every code, back-to-back where the ALU allows.
        for (int i = 0; i < 32; i++) begin
            logic [2:0]  code;
            logic [31:0] a, b;
            code = 3'(i % 8);
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            issue(code, a, b);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(scb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
